// File: rtl/dpram_fifo_ctrl.sv
// Stream-to-RAM FIFO controller for an external 1-cycle-latency dual-port RAM.
// A 2-entry output buffer holds the show-ahead head word(s) returned from the RAM.
module dpram_fifo_ctrl #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 8,
   parameter int AF_TH  = 240,
   parameter int AE_TH  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_flush,
   input  logic              i_s_valid,
   output logic              o_s_ready,
   input  logic [DATA_W-1:0] i_s_data,
   output logic              o_m_valid,
   input  logic              i_m_ready,
   output logic [DATA_W-1:0] o_m_data,
   output logic              o_ram_wr_en,
   output logic [ADDR_W-1:0] o_ram_wr_addr,
   output logic [DATA_W-1:0] o_ram_data_in,
   output logic              o_ram_rd_en,
   output logic [ADDR_W-1:0] o_ram_rd_addr,
   input  logic [DATA_W-1:0] i_ram_data_out,
   output logic [ADDR_W+1:0] o_count,
   output logic              o_full,
   output logic              o_empty,
   output logic              o_almost_full,
   output logic              o_almost_empty
);

   localparam int DEPTH = 2 ** ADDR_W;
   localparam int RCW   = ADDR_W + 1;
   localparam int CW    = ADDR_W + 2;

   logic [ADDR_W-1:0] r_wr_ptr;
   logic [ADDR_W-1:0] r_rd_ptr;
   logic [RCW-1:0]    r_ram_cnt;
   logic              r_inflight;
   logic [1:0]        r_ob_cnt;
   logic              r_ob_head;
   logic              r_init_done;
   logic [DATA_W-1:0] r_ob_data [0:1];

   logic              w_push;
   logic              w_pop;
   logic              w_ret;
   logic              w_ob_tail;
   logic [2:0]        w_ob_busy;

   assign o_s_ready     = r_init_done && !i_flush && (r_ram_cnt < RCW'(DEPTH));
   assign w_push        = i_s_valid && o_s_ready;
   assign o_ram_wr_en   = w_push;
   assign o_ram_wr_addr = r_wr_ptr;
   assign o_ram_data_in = i_s_data;

   // Slots already claimed in the output buffer, counting the read still in the RAM pipe.
   assign w_ob_busy     = {1'b0, r_ob_cnt} + {2'b00, r_inflight};
   assign o_ram_rd_en   = !i_flush && (r_ram_cnt != '0) && (w_ob_busy < 3'd2);
   assign o_ram_rd_addr = r_rd_ptr;

   assign o_m_valid = (r_ob_cnt != 2'd0);
   assign o_m_data  = r_ob_data[r_ob_head];
   assign w_pop     = o_m_valid && i_m_ready && !i_flush;
   assign w_ret     = r_inflight && !i_flush;
   assign w_ob_tail = r_ob_head ^ (r_ob_cnt == 2'd1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_ram_cnt   <= '0;
         r_inflight  <= 1'b0;
         r_ob_cnt    <= 2'd0;
         r_ob_head   <= 1'b0;
         r_init_done <= 1'b0;
      end else begin
         r_init_done <= 1'b1;
         if (i_flush) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_ram_cnt  <= '0;
            r_inflight <= 1'b0;
            r_ob_cnt   <= 2'd0;
            r_ob_head  <= 1'b0;
         end else begin
            if (w_push) begin
               r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (o_ram_rd_en) begin
               r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, o_ram_rd_en})
               2'b10:   r_ram_cnt <= r_ram_cnt + 1'b1;
               2'b01:   r_ram_cnt <= r_ram_cnt - 1'b1;
               default: r_ram_cnt <= r_ram_cnt;
            endcase
            r_inflight <= o_ram_rd_en;
            if (w_pop) begin
               r_ob_head <= ~r_ob_head;
            end
            case ({w_ret, w_pop})
               2'b10:   r_ob_cnt <= r_ob_cnt + 2'd1;
               2'b01:   r_ob_cnt <= r_ob_cnt - 2'd1;
               default: r_ob_cnt <= r_ob_cnt;
            endcase
         end
      end
   end

   // Data storage needs no reset; occupancy is tracked by r_ob_cnt.
   always_ff @(posedge clk) begin
      if (w_ret) begin
         r_ob_data[w_ob_tail] <= i_ram_data_out;
      end
   end

   assign o_count        = CW'(r_ram_cnt) + CW'(r_inflight) + CW'(r_ob_cnt);
   assign o_full         = r_init_done && (r_ram_cnt == RCW'(DEPTH));
   assign o_empty        = (o_count == '0);
   assign o_almost_full  = (o_count >= CW'(AF_TH));
   assign o_almost_empty = (o_count <= CW'(AE_TH));

endmodule

// File: tb/tb_dpram_fifo_ctrl.sv
// Bench for dpram_fifo_ctrl: behavioural RAM, scoreboard queue of pushed words,
// popped words and occupancy checked against the queue on every falling edge.
module tb_dpram_fifo_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       flush = 1'b0;
   logic       s_valid = 1'b0;
   logic       s_ready;
   logic [7:0] s_data = 8'h00;
   logic       m_valid;
   logic       m_ready = 1'b0;
   logic [7:0] m_data;
   logic       ram_wr_en;
   logic [7:0] ram_wr_addr;
   logic [7:0] ram_data_in;
   logic       ram_rd_en;
   logic [7:0] ram_rd_addr;
   logic [7:0] ram_data_out;
   logic [9:0] count;
   logic       full, empty, almost_full, almost_empty;

   logic [7:0] ram_mem [0:255];
   logic [7:0] sb_q [$];
   int         n_checks = 0;
   int         n_fail = 0;
   int         n_pops = 0;
   int         n_pushes = 0;

   always #5 clk = ~clk;

   dpram_fifo_ctrl #(.DATA_W(8), .ADDR_W(8), .AF_TH(240), .AE_TH(16)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .i_flush        (flush),
      .i_s_valid      (s_valid),
      .o_s_ready      (s_ready),
      .i_s_data       (s_data),
      .o_m_valid      (m_valid),
      .i_m_ready      (m_ready),
      .o_m_data       (m_data),
      .o_ram_wr_en    (ram_wr_en),
      .o_ram_wr_addr  (ram_wr_addr),
      .o_ram_data_in  (ram_data_in),
      .o_ram_rd_en    (ram_rd_en),
      .o_ram_rd_addr  (ram_rd_addr),
      .i_ram_data_out (ram_data_out),
      .o_count        (count),
      .o_full         (full),
      .o_empty        (empty),
      .o_almost_full  (almost_full),
      .o_almost_empty (almost_empty)
   );

   // Dual-port RAM with registered read, as seen by the controller.
   always @(posedge clk) begin
      if (ram_wr_en) ram_mem[ram_wr_addr] <= ram_data_in;
      if (ram_rd_en) ram_data_out <= ram_mem[ram_rd_addr];
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Scoreboard: occupancy reflects the previous edge; handshakes are taken for the next one.
   always @(negedge clk) begin
      if (rst_n) begin
         chk("count", 32'(count), 32'(sb_q.size()));
         chk("empty", 32'(empty), 32'(sb_q.size() == 0));
         chk("almost_full", 32'(almost_full), 32'(sb_q.size() >= 240));
         chk("almost_empty", 32'(almost_empty), 32'(sb_q.size() <= 16));
         if (ram_wr_en && ram_rd_en)
            chk("rw_same_addr", 32'(ram_wr_addr == ram_rd_addr), 32'd0);
         if (flush) begin
            sb_q.delete();
         end else begin
            if (m_valid && m_ready) begin
               n_pops++;
               if (sb_q.size() == 0) chk("pop_underrun", 32'd1, 32'd0);
               else chk("m_data", 32'(m_data), 32'(sb_q.pop_front()));
            end
            if (s_valid && s_ready) begin
               sb_q.push_back(s_data);
               n_pushes++;
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Called and returns at posedge+1.
   task automatic push_word(input logic [7:0] d);
      s_valid = 1'b1;
      s_data  = d;
      for (int t = 0; ; t++) begin
         @(negedge clk);
         if (s_ready) break;
         if (t >= 300) begin
            chk("push_timeout", 32'd1, 32'd0);
            break;
         end
      end
      tick();
      s_valid = 1'b0;
   endtask

   task automatic drain(input string name);
      m_ready = 1'b1;
      for (int t = 0; ; t++) begin
         @(negedge clk);
         if (count == 10'd0) break;
         if (t >= 3000) begin
            chk("drain_timeout", 32'd1, 32'd0);
            break;
         end
      end
      tick();
      m_ready = 1'b0;
      $display("%s: drained, pushes=%0d pops=%0d", name, n_pushes, n_pops);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int  d;
      int  pops0;
      logic acc;

      // Reset with random push attempts
      rst_n = 1'b0;
      repeat (3) begin
         tick();
         s_valid = 1'($urandom_range(0, 1));
         s_data  = 8'($urandom_range(0, 255));
         @(negedge clk);
         chk("rst_wr_en", 32'(ram_wr_en), 32'd0);
         chk("rst_rd_en", 32'(ram_rd_en), 32'd0);
         chk("rst_m_valid", 32'(m_valid), 32'd0);
         chk("rst_count", 32'(count), 32'd0);
         chk("rst_flags", {28'd0, empty, full, almost_empty, almost_full}, 32'b1010);
         chk("rst_s_ready", 32'(s_ready), 32'd0);
      end
      tick();
      rst_n   = 1'b1;
      s_valid = 1'b0;
      @(negedge clk);
      chk("init_s_ready_pre", 32'(s_ready), 32'd0);
      tick();
      @(negedge clk);
      chk("init_s_ready", 32'(s_ready), 32'd1);
      $display("reset: done");

      // Single word latency
      tick();
      s_valid = 1'b1;
      s_data  = 8'hA5;
      @(negedge clk);
      chk("sw_wr_en", 32'(ram_wr_en), 32'd1);
      chk("sw_wr_addr", 32'(ram_wr_addr), 32'd0);
      chk("sw_data_in", 32'(ram_data_in), 32'hA5);
      tick();
      s_valid = 1'b0;
      @(negedge clk);
      chk("sw_rd_en", 32'(ram_rd_en), 32'd1);
      chk("sw_rd_addr", 32'(ram_rd_addr), 32'd0);
      chk("sw_m_valid_e0", 32'(m_valid), 32'd0);
      tick();
      @(negedge clk);
      chk("sw_m_valid_e1", 32'(m_valid), 32'd0);
      tick();
      @(negedge clk);
      chk("sw_m_valid_e2", 32'(m_valid), 32'd1);
      chk("sw_m_data", 32'(m_data), 32'hA5);
      tick();
      drain("single");

      // Fill to full with the output side stalled
      for (int i = 0; i < 258; i++) push_word(8'(i));
      repeat (3) tick();
      @(negedge clk);
      chk("fill_count", 32'(count), 32'd258);
      chk("fill_full", 32'(full), 32'd1);
      chk("fill_s_ready", 32'(s_ready), 32'd0);
      chk("fill_almost_full", 32'(almost_full), 32'd1);
      tick();
      s_valid = 1'b1;
      s_data  = 8'hEE;
      repeat (3) begin
         @(negedge clk);
         chk("fill_blocked_wr", 32'(ram_wr_en), 32'd0);
         tick();
      end
      s_valid = 1'b0;
      m_ready = 1'b1;
      @(negedge clk);
      tick();
      m_ready = 1'b0;
      @(negedge clk);
      chk("pf_s_ready_1", 32'(s_ready), 32'd0);
      tick();
      @(negedge clk);
      chk("pf_s_ready_2", 32'(s_ready), 32'd1);
      tick();
      $display("fill: count reached 258, pushes=%0d", n_pushes);
      drain("fill");

      // Streaming with pointer wrap
      s_valid = 1'b1;
      m_ready = 1'b1;
      d       = 0;
      pops0   = n_pops;
      for (int c = 0; c < 1000; c++) begin
         s_data = 8'(d);
         @(negedge clk);
         acc = s_ready;
         tick();
         if (acc) d++;
      end
      s_valid = 1'b0;
      chk("stream_rate", 32'((n_pops - pops0) >= 600), 32'd1);
      $display("stream: pushed=%0d popped=%0d in 1000 cycles", d, n_pops - pops0);
      drain("stream");

      // Random backpressure
      s_valid = 1'b1;
      for (int c = 0; c < 800; c++) begin
         s_data  = 8'(d);
         m_ready = ($urandom_range(0, 99) < 30);
         @(negedge clk);
         acc = s_ready;
         tick();
         if (acc) d++;
      end
      s_valid = 1'b0;
      drain("backpressure");

      // Flush while a RAM read is returning
      for (int i = 0; i < 51; i++) push_word(8'(8'h80 + i));
      repeat (4) tick();
      m_ready = 1'b1;
      @(negedge clk);
      tick();
      m_ready = 1'b0;
      tick();
      flush = 1'b1;
      @(negedge clk);
      chk("fl_pre_count", 32'(count), 32'd50);
      chk("fl_rd_en", 32'(ram_rd_en), 32'd0);
      chk("fl_s_ready", 32'(s_ready), 32'd0);
      tick();
      flush = 1'b0;
      @(negedge clk);
      chk("fl_count", 32'(count), 32'd0);
      chk("fl_m_valid", 32'(m_valid), 32'd0);
      tick();
      @(negedge clk);
      chk("fl_m_valid_2", 32'(m_valid), 32'd0);
      tick();
      push_word(8'h3C);
      repeat (3) tick();
      @(negedge clk);
      chk("fl_new_valid", 32'(m_valid), 32'd1);
      chk("fl_new_data", 32'(m_data), 32'h3C);
      tick();
      drain("flush");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
